// File: rtl/pkt_hdr_capture.sv
// ----------------------------------------------------------------------------
// pkt_hdr_capture
//   Captures the first four beats of every AXI-Stream packet, masks bytes
//   whose tkeep bit is clear, and emits a packed header vector one cycle
//   after the tlast beat. The vector holds the raw beats, 24 byte containers
//   (packet bytes 14..37) and the packet length in beats (saturating at 127).
//
// Ports
//   clk            : clock, rising edge
//   aresetn        : synchronous active-low reset
//   s_axis_tdata   : beat data, packet byte n of the beat on [8n+7:8n]
//   s_axis_tkeep   : byte-valid mask
//   s_axis_tvalid  : beat accepted (no backpressure)
//   s_axis_tlast   : last beat of the packet
//   parser_valid   : one-cycle pulse, pkt_hdr_vec valid
//   pkt_hdr_vec    : header vector (held between emissions)
// ----------------------------------------------------------------------------
module pkt_hdr_capture #(
    parameter int unsigned C_S_AXIS_DATA_WIDTH = 256,
    parameter int unsigned PKT_VEC_WIDTH       = 1735
) (
    input  logic                               clk,
    input  logic                               aresetn,
    input  logic [C_S_AXIS_DATA_WIDTH-1:0]     s_axis_tdata,
    input  logic [C_S_AXIS_DATA_WIDTH/8-1:0]   s_axis_tkeep,
    input  logic                               s_axis_tvalid,
    input  logic                               s_axis_tlast,
    output logic                               parser_valid,
    output logic [PKT_VEC_WIDTH-1:0]           pkt_hdr_vec
);

    localparam int unsigned DW           = C_S_AXIS_DATA_WIDTH;
    localparam int unsigned KW           = C_S_AXIS_DATA_WIDTH / 8;
    localparam int unsigned NSEG         = 4;
    localparam int unsigned CNT_W        = 7;
    localparam int unsigned CONT_LO      = 512;
    localparam int unsigned LEN_LO       = 704;
    localparam int unsigned SEG_LO       = 711;
    localparam int unsigned NCONT_S0     = 18;
    localparam int unsigned CONT_S0_BYTE = 14;
    localparam int unsigned NCONT_S1     = 6;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(127);

    typedef enum logic [0:0] {
        FIRST_BEAT = 1'b0,
        IN_PKT     = 1'b1
    } state_t;

    state_t                 state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [DW-1:0]          seg_q [NSEG];
    logic [DW-1:0]          seg_d [NSEG];
    logic                   valid_q, valid_d;
    logic [PKT_VEC_WIDTH-1:0] vec_q, vec_d;
    logic [DW-1:0]          beat_masked;

    // Zero every byte whose keep bit is clear
    always_comb begin
        beat_masked = '0;
        for (int unsigned b = 0; b < KW; b++) begin
            if (s_axis_tkeep[b]) begin
                beat_masked[8*b +: 8] = s_axis_tdata[8*b +: 8];
            end
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (!aresetn) begin
            state_q <= FIRST_BEAT;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            FIRST_BEAT: begin
                if (s_axis_tvalid && !s_axis_tlast) begin
                    state_d = IN_PKT;
                end
            end
            IN_PKT: begin
                if (s_axis_tvalid && s_axis_tlast) begin
                    state_d = FIRST_BEAT;
                end
            end
            default: state_d = FIRST_BEAT;
        endcase
    end

    // Datapath / output next values
    always_comb begin
        cnt_d   = cnt_q;
        seg_d   = seg_q;
        valid_d = 1'b0;
        case (state_q)
            FIRST_BEAT: begin
                if (s_axis_tvalid) begin
                    // A new packet wipes any leftovers from a longer predecessor
                    seg_d[0] = beat_masked;
                    for (int unsigned k = 1; k < NSEG; k++) begin
                        seg_d[k] = '0;
                    end
                    cnt_d   = CNT_W'(1);
                    valid_d = s_axis_tlast;
                end
            end
            IN_PKT: begin
                if (s_axis_tvalid) begin
                    if (cnt_q < CNT_W'(NSEG)) begin
                        seg_d[cnt_q[1:0]] = beat_masked;
                    end
                    if (cnt_q != CNT_MAX) begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                    valid_d = s_axis_tlast;
                end
            end
            default: begin
                valid_d = 1'b0;
            end
        endcase
    end

    // Header vector assembled from the post-update working set, so the tlast
    // beat itself is included without an extra cycle of latency
    always_comb begin
        vec_d = '0;
        for (int unsigned i = 0; i < NCONT_S0; i++) begin
            vec_d[CONT_LO + 8*i +: 8] = seg_d[0][8*(CONT_S0_BYTE + i) +: 8];
        end
        for (int unsigned i = 0; i < NCONT_S1; i++) begin
            vec_d[CONT_LO + 8*(NCONT_S0 + i) +: 8] = seg_d[1][8*i +: 8];
        end
        vec_d[LEN_LO +: CNT_W] = cnt_d;
        for (int unsigned k = 0; k < NSEG; k++) begin
            vec_d[SEG_LO + DW*k +: DW] = seg_d[k];
        end
    end

    // Working registers and output registers
    always_ff @(posedge clk) begin
        if (!aresetn) begin
            cnt_q   <= '0;
            for (int unsigned k = 0; k < NSEG; k++) begin
                seg_q[k] <= '0;
            end
            valid_q <= 1'b0;
            vec_q   <= '0;
        end else begin
            cnt_q   <= cnt_d;
            seg_q   <= seg_d;
            valid_q <= valid_d;
            if (valid_d) begin
                vec_q <= vec_d;
            end
        end
    end

    assign parser_valid = valid_q;
    assign pkt_hdr_vec  = vec_q;

endmodule

// File: tb/tb_pkt_hdr_capture.sv
// ----------------------------------------------------------------------------
// tb_pkt_hdr_capture
//   Directed packets are driven on the falling edge; each expected header
//   vector and its expected pulse cycle are queued at issue time. A monitor
//   on the falling edge pops and compares on every parser_valid pulse and
//   checks that the vector is held between pulses.
// ----------------------------------------------------------------------------
module tb_pkt_hdr_capture;

    localparam int unsigned DW = 256;
    localparam int unsigned KW = 32;
    localparam int unsigned VW = 1735;

    logic          clk = 1'b0;
    logic          aresetn;
    logic [DW-1:0] s_axis_tdata;
    logic [KW-1:0] s_axis_tkeep;
    logic          s_axis_tvalid;
    logic          s_axis_tlast;
    logic          parser_valid;
    logic [VW-1:0] pkt_hdr_vec;

    pkt_hdr_capture #(
        .C_S_AXIS_DATA_WIDTH(DW),
        .PKT_VEC_WIDTH      (VW)
    ) dut (
        .clk          (clk),
        .aresetn      (aresetn),
        .s_axis_tdata (s_axis_tdata),
        .s_axis_tkeep (s_axis_tkeep),
        .s_axis_tvalid(s_axis_tvalid),
        .s_axis_tlast (s_axis_tlast),
        .parser_valid (parser_valid),
        .pkt_hdr_vec  (pkt_hdr_vec)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [VW-1:0] vec;
        int            cyc;
    } exp_t;

    exp_t          sb_q[$];
    exp_t          mon_e;
    logic [VW-1:0] last_exp;
    int            cyc = 0;
    int            drv_cyc = 0;
    int            n_chk = 0;
    int            n_pass = 0;
    logic          mon_en = 1'b0;
    logic          rst_seen = 1'b1;
    logic [DW-1:0] td1;

    always @(posedge clk) begin
        cyc      <= cyc + 1;
        rst_seen <= !aresetn;
    end

    function automatic logic [DW-1:0] fill(input logic [7:0] b);
        return {32{b}};
    endfunction

    // Header layout built from hand-specified segments and length
    function automatic logic [VW-1:0] mkvec(input logic [DW-1:0] s0, input logic [DW-1:0] s1,
                                            input logic [DW-1:0] s2, input logic [DW-1:0] s3,
                                            input int len);
        logic [VW-1:0] v;
        v = '0;
        for (int i = 0; i < 18; i++) v[512 + 8*i +: 8] = s0[8*(14 + i) +: 8];
        for (int i = 0; i < 6; i++)  v[512 + 8*(18 + i) +: 8] = s1[8*i +: 8];
        v[710:704] = 7'(len);
        v[711 +: 256]  = s0;
        v[967 +: 256]  = s1;
        v[1223 +: 256] = s2;
        v[1479 +: 256] = s3;
        return v;
    endfunction

    task automatic chk_int(input string name, input int got, input int exp);
        n_chk++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, got, exp);
    endtask

    // Reports the first differing 64-bit word to keep lines short
    task automatic chk_vec(input string name, input logic [VW-1:0] got, input logic [VW-1:0] exp);
        logic [1791:0] g, e;
        n_chk++;
        if (got === exp) begin
            n_pass++;
        end else begin
            g = 1792'(got);
            e = 1792'(exp);
            for (int w = 0; w < 28; w++) begin
                if (g[64*w +: 64] !== e[64*w +: 64]) begin
                    $display("FAIL %s cyc=%0d: word%0d got %h expected %h", name, cyc, w,
                             g[64*w +: 64], e[64*w +: 64]);
                    break;
                end
            end
        end
    endtask

    task automatic beat(input logic [DW-1:0] d, input logic [KW-1:0] k, input logic last);
        @(negedge clk);
        aresetn       = 1'b1;
        s_axis_tdata  = d;
        s_axis_tkeep  = k;
        s_axis_tvalid = 1'b1;
        s_axis_tlast  = last;
        drv_cyc       = cyc;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            aresetn       = 1'b1;
            s_axis_tvalid = 1'b0;
            s_axis_tlast  = 1'b0;
        end
    endtask

    // Expected pulse appears the cycle after the tlast beat is accepted
    task automatic push(input logic [VW-1:0] v);
        exp_t e;
        e.vec = v;
        e.cyc = drv_cyc + 1;
        sb_q.push_back(e);
    endtask

    // Monitor: compare on each pulse, check hold otherwise
    always @(negedge clk) begin
        if (mon_en) begin
            if (rst_seen) last_exp = '0;
            if (parser_valid === 1'b1) begin
                if (sb_q.size() == 0) begin
                    n_chk++;
                    $display("FAIL unexpected_pulse cyc=%0d: got parser_valid=1 expected 0", cyc);
                end else begin
                    mon_e = sb_q.pop_front();
                    chk_int("pulse_cycle", cyc, mon_e.cyc);
                    chk_vec("pulse_vec", pkt_hdr_vec, mon_e.vec);
                    last_exp = mon_e.vec;
                end
            end else if (parser_valid !== 1'b0) begin
                n_chk++;
                $display("FAIL parser_valid_x cyc=%0d: got %b expected 0", cyc, parser_valid);
            end else begin
                chk_vec("hold_vec", pkt_hdr_vec, last_exp);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    initial begin
        aresetn       = 1'b0;
        s_axis_tdata  = '0;
        s_axis_tkeep  = '0;
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
        last_exp      = '0;
        repeat (3) @(negedge clk);
        chk_int("reset_valid", int'(parser_valid), 0);
        chk_vec("reset_vec", pkt_hdr_vec, '0);
        mon_en = 1'b1;

        // Single beat, byte n = n
        for (int n = 0; n < 32; n++) td1[8*n +: 8] = 8'(n);
        beat(td1, '1, 1'b1);
        push(mkvec(td1, '0, '0, '0, 1));
        idle(2);

        // Six beats, last beat keeps 4 bytes only
        for (int k = 0; k < 6; k++) beat(fill(8'(8'h10 + k)), (k == 5) ? 32'h0000000F : 32'hFFFFFFFF, k == 5);
        push(mkvec(fill(8'h10), fill(8'h11), fill(8'h12), fill(8'h13), 6));
        idle(2);

        // Two 2-beat packets back to back
        beat(fill(8'hA0), '1, 1'b0);
        beat(fill(8'hA1), '1, 1'b1);
        push(mkvec(fill(8'hA0), fill(8'hA1), '0, '0, 2));
        beat(fill(8'hB0), '1, 1'b0);
        beat(fill(8'hB1), '1, 1'b1);
        push(mkvec(fill(8'hB0), fill(8'hB1), '0, '0, 2));
        idle(2);

        // Idle gap mid-packet, partial keep on last beat
        beat(fill(8'h55), '1, 1'b0);
        idle(3);
        beat(fill(8'h66), 32'h00000007, 1'b1);
        push(mkvec(fill(8'h55), {232'h0, 24'h666666}, '0, '0, 2));
        idle(2);

        // Reset mid-packet; a tlast beat during reset is ignored
        beat(fill(8'h70), '1, 1'b0);
        beat(fill(8'h71), '1, 1'b0);
        beat(fill(8'h72), '1, 1'b0);
        @(negedge clk);
        aresetn       = 1'b0;
        s_axis_tdata  = fill(8'hEE);
        s_axis_tkeep  = '1;
        s_axis_tvalid = 1'b1;
        s_axis_tlast  = 1'b1;
        beat(fill(8'h99), '1, 1'b1);
        push(mkvec(fill(8'h99), '0, '0, '0, 1));
        idle(2);

        // Long packet: length saturates, only first four beats captured
        for (int k = 0; k < 130; k++) beat(fill(8'(k)), '1, k == 129);
        push(mkvec(fill(8'h00), fill(8'h01), fill(8'h02), fill(8'h03), 127));
        idle(2);

        // Counter restarts after saturation; upper half kept only
        beat(fill(8'h42), 32'hFFFF0000, 1'b1);
        push(mkvec({{16{8'h42}}, 128'h0}, '0, '0, '0, 1));
        idle(2);

        for (int i = 0; i < 20 && sb_q.size() != 0; i++) @(negedge clk);
        chk_int("queue_drained", sb_q.size(), 0);
        idle(3);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/pkt_hdr_capture.md
PKT_HDR_CAPTURE -- requirements
Module: pkt_hdr_capture

Interface
- REQ-001: The block SHALL have parameter C_S_AXIS_DATA_WIDTH, default 256, input stream data width in bits.
- REQ-002: The block SHALL have parameter PKT_VEC_WIDTH, default 1735, packet header vector width in bits.
- REQ-003: The block SHALL have port clk, input, 1 bit, clock; all logic on its rising edge.
- REQ-004: The block SHALL have port aresetn, input, 1 bit, synchronous active-low reset.
- REQ-005: The block SHALL have port s_axis_tdata, input, 256 bits, beat data; packet byte n of the beat is on bits [8n+7:8n].
- REQ-006: The block SHALL have port s_axis_tkeep, input, 32 bits, byte-valid mask.
- REQ-007: The block SHALL have port s_axis_tvalid, input, 1 bit, beat accepted; already qualified with tready upstream, so no backpressure exists.
- REQ-008: The block SHALL have port s_axis_tlast, input, 1 bit, last beat of the packet.
- REQ-009: The block SHALL have port parser_valid, output, 1 bit, one-cycle pulse marking pkt_hdr_vec valid.
- REQ-010: The block SHALL have port pkt_hdr_vec, output, PKT_VEC_WIDTH bits, header vector.

Function
- REQ-011: pkt_hdr_vec layout SHALL be as follows:
  - [511:0]: reserved, always 0.
  - [703:512]: 24 byte containers; container i at [512+8i+:8] = packet byte 14+i.
  - [710:704]: tot_length.
  - [711+256k+:256]: segment k = captured beat k, for k=0..3.
- REQ-012: The FSM SHALL have two states:
  - FIRST_BEAT (reset state).
  - IN_PKT.
- REQ-013: In FIRST_BEAT, a beat with tvalid SHALL:
  - be stored as segment 0;
  - set the beat counter to 1;
  - clear segments 1-3.
  - If tlast=0, go to IN_PKT; if tlast=1, stay in FIRST_BEAT and emit.
- REQ-014: In IN_PKT, each valid beat SHALL:
  - be stored as segment[count] while count<4, otherwise not stored;
  - increment the counter, saturating at 127.
  - On tlast, return to FIRST_BEAT and emit.
- REQ-015: Captured segment bytes whose tkeep bit is 0 SHALL be stored as 0x00.
- REQ-016: Containers SHALL be taken from segment 0 bytes 14-31 (containers 0-17) and segment 1 bytes 0-5 (containers 18-23). They read 0 if those bytes were not received or were masked.
- REQ-017: tot_length SHALL equal the number of beats in the packet, tlast beat included, saturating at 127.
- REQ-018: Emission latency SHALL be exactly 1 cycle: parser_valid=1 in the cycle after the tlast beat is accepted, with pkt_hdr_vec fully formed in that same cycle.
- REQ-019: parser_valid SHALL be 1 for exactly one cycle per packet and 0 otherwise.
- REQ-020: pkt_hdr_vec SHALL be a dedicated output register, held stable between emissions, and updated only in the emit cycle.
- REQ-021: Back-to-back packets SHALL be supported: the first beat of packet B in the cycle right after A's tlast is captured into the working registers. A's emission in that cycle is unaffected.
- REQ-022: A single-beat packet SHALL emit segments 1-3 = 0, containers 18-23 = 0, and tot_length=1.
- REQ-023: Idle cycles (tvalid=0) mid-packet SHALL change neither state, counter, nor segments.
- REQ-024: The sustained rate SHALL be one beat per cycle with no bubbles required.

Reset
- REQ-025: While aresetn=0, the block SHALL drive:
  - state=FIRST_BEAT;
  - counter=0;
  - working segments=0;
  - pkt_hdr_vec=0;
  - parser_valid=0.
- REQ-026: Reset mid-packet SHALL discard the partial packet without emission. The first valid beat after release is treated as beat 0.
- REQ-027: A beat presented during a reset cycle SHALL be ignored.

Verification
- REQ-028: Single beat, tdata byte n = n, tkeep=all 1s, tlast=1 -> next cycle:
  - parser_valid=1;
  - segment0 byte n = n;
  - container i = 14+i for i<18; containers 18-23 = 0;
  - tot_length=1.
- REQ-029: 6-beat packet, beat k filled with 0x10+k, last tkeep=0x0000000F -> 1 pulse, one cycle after beat 5, with:
  - segments 0-3 = 0x10..0x13 repeated;
  - containers 0-17 = 0x10, containers 18-23 = 0x11;
  - tot_length=6.
- REQ-030: Two 2-beat packets back-to-back, no gaps -> parser_valid pulses in cycles 2 and 4 (beat 0 in cycle 0). Each vector reflects only its own packet, and segments 2-3 = 0.
- REQ-031: 2-beat packet, beat 1 tkeep=0x00000007 with 3 idle cycles between beats -> one pulse, one cycle after beat 1. Segment1 bytes 3-31 = 0, tot_length=2.
- REQ-032: 3 beats, then aresetn low 1 cycle, then a 1-beat packet -> no pulse for the aborted packet. One pulse for the new packet with tot_length=1 and segments 1-3 = 0.
- REQ-033: 130-beat packet -> one pulse with tot_length=127 and segments 0-3 = beats 0-3.
